// File: rtl/fir_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared definitions for the multi-cycle FIR sequencer: scheduler
//            state encoding, 4-bit counter type, default datapath constants
//            and the host configuration bus widths.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Counter width shared by the cycle and latency counters.
  localparam int C_CNT_W = 4;
  typedef logic [C_CNT_W-1:0] cnt_t;

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STALL = 2'd3
  } fsm_state_e;

  // FIR datapath defaults.
  localparam int C_FIR_DW  = 16;  // sample / result width
  localparam int C_FIR_N   = 8;   // datapath cycles per sample
  localparam int C_FIR_LAT = 2;   // result latency after the last cycle

  // Host coefficient bus.
  localparam int C_CFG_AW = 8;
  localparam int C_CFG_DW = 32;

  // Terminal value of a counter that must step through n values (0..n-1).
  function automatic cnt_t last_count(input int unsigned n);
    return cnt_t'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_out_reg
// Purpose  : One-entry valid/ready output holding register. A load takes
//            priority over a same-edge drain, so back-to-back results keep
//            tvalid high with the new data.
// Ports    : clk_i, rst_ni (async, active low), en_i (clock enable),
//            load_i/data_i (capture request), tdata_o/tvalid_o/tready_i
//            (downstream stream).
// Revision : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] tdata_o,
  output logic          tvalid_o,
  input  logic          tready_i
);

  logic [DW-1:0] tdata_q;
  logic          tvalid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else if (en_i) begin
      if (load_i) begin
        tdata_q  <= data_i;
        tvalid_q <= 1'b1;
      end else if (tvalid_q && tready_i) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign tdata_o  = tdata_q;
  assign tvalid_o = tvalid_q;

endmodule
`default_nettype wire

// File: rtl/fir_mc_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fir_mc_sched
// Purpose  : Sequencer for a multi-cycle FIR datapath. Accepts one sample,
//            steps the datapath through N cycles, waits LAT cycles for the
//            result and hands it to a one-entry output register. Coefficient
//            writes from the host are forwarded only while idle, so the
//            coefficients never change in the middle of a sample.
// Ports    : sys_clk, reset_n (async, active low), ce (global clock enable)
//            s_t*      : sample input stream
//            m_t*      : filtered output stream
//            fir_*     : datapath sequencing (sample, load, cycle, result)
//            cfg_*     : host coefficient write port
//            coeff_*   : forwarded coefficient write
//            busy_o    : scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module fir_mc_sched
  import fir_pkg::*;
#(
  parameter int DW  = C_FIR_DW,
  parameter int N   = C_FIR_N,
  parameter int LAT = C_FIR_LAT
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [DW-1:0]       s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DW-1:0]       m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DW-1:0]       fir_sample_o,
  output logic                fir_load_o,
  output logic [C_CNT_W-1:0]  fir_cycle_o,
  input  logic [DW-1:0]       fir_result_i,
  input  logic [C_CFG_AW-1:0] cfg_addr,
  input  logic [C_CFG_DW-1:0] cfg_wdata,
  input  logic                cfg_wr,
  output logic                cfg_ready,
  output logic [C_CFG_AW-1:0] coeff_addr,
  output logic [C_CFG_DW-1:0] coeff_wdata,
  output logic                coeff_wr,
  output logic                busy_o
);

  localparam cnt_t C_CYC_LAST = last_count(N);
  localparam cnt_t C_LAT_LAST = last_count(LAT);

  fsm_state_e          state_q;
  cnt_t                cyc_q;
  cnt_t                lat_q;
  logic [DW-1:0]       sample_q;
  logic                load_q;
  logic                busy_q;
  logic [C_CFG_AW-1:0] caddr_q;
  logic [C_CFG_DW-1:0] cwdata_q;
  logic                cwr_q;

  logic idle_w;
  logic cfg_fire_w;
  logic s_fire_w;
  logic wait_last_w;
  logic capture_w;

  assign idle_w     = (state_q == ST_IDLE);
  assign cfg_ready  = ce & idle_w;
  // A pending coefficient write blocks the sample for this cycle.
  assign s_tready   = ce & idle_w & ~cfg_wr;
  assign cfg_fire_w = cfg_wr & cfg_ready;
  assign s_fire_w   = s_tvalid & s_tready;

  assign wait_last_w = (state_q == ST_WAIT) && (lat_q == C_LAT_LAST);

  // Capture when the result is due and the output slot is free (empty, or
  // being drained on this same edge); from STALL the slot is known full, so
  // only a downstream ready frees it.
  assign capture_w = ce & ((wait_last_w & (~m_tvalid | m_tready)) |
                           ((state_q == ST_STALL) & m_tready));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      lat_q    <= '0;
      sample_q <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      caddr_q  <= '0;
      cwdata_q <= '0;
      cwr_q    <= 1'b0;
    end else if (ce) begin
      // Single-cycle strobes.
      load_q <= 1'b0;
      cwr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_fire_w) begin
            caddr_q  <= cfg_addr;
            cwdata_q <= cfg_wdata;
            cwr_q    <= 1'b1;
          end else if (s_fire_w) begin
            sample_q <= s_tdata;
            load_q   <= 1'b1;
            cyc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cyc_q == C_CYC_LAST) begin
            // Cycle output returns to 0 outside RUN.
            cyc_q   <= '0;
            lat_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            cyc_q <= cyc_q + cnt_t'(1);
          end
        end
        ST_WAIT: begin
          if (lat_q == C_LAT_LAST) begin
            lat_q <= '0;
            if (capture_w) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_STALL;
            end
          end else begin
            lat_q <= lat_q + cnt_t'(1);
          end
        end
        ST_STALL: begin
          if (capture_w) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  axis_out_reg #(
    .DW (DW)
  ) u_out_reg (
    .clk_i    (sys_clk),
    .rst_ni   (reset_n),
    .en_i     (ce),
    .load_i   (capture_w),
    .data_i   (fir_result_i),
    .tdata_o  (m_tdata),
    .tvalid_o (m_tvalid),
    .tready_i (m_tready)
  );

  assign fir_sample_o = sample_q;
  assign fir_load_o   = load_q;
  assign fir_cycle_o  = cyc_q;
  assign coeff_addr   = caddr_q;
  assign coeff_wdata  = cwdata_q;
  assign coeff_wr     = cwr_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mc_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fir_mc_sched
// Purpose  : Self-checking bench for fir_mc_sched. A stand-in datapath
//            returns sample XOR KEY, so every delivered result can be
//            predicted from the sample that was sent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mc_sched;

  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int LAT = 2;
  localparam logic [DW-1:0] KEY = 16'hA5C3;

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] fir_sample_o;
  logic          fir_load_o;
  logic [3:0]    fir_cycle_o;
  logic [DW-1:0] fir_result_i;
  logic [7:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          cfg_wr;
  logic          cfg_ready;
  logic [7:0]    coeff_addr;
  logic [31:0]   coeff_wdata;
  logic          coeff_wr;
  logic          busy_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] d, dA, dB, e;
  logic [7:0]    ra;
  logic [31:0]   rw;
  int            lat, wr_cnt, wr_at, t;
  bit            spur;

  always #5 sys_clk = ~sys_clk;

  assign fir_result_i = fir_sample_o ^ KEY;

  fir_mc_sched #(.DW(DW), .N(N), .LAT(LAT)) dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .ce           (ce),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .fir_sample_o (fir_sample_o),
    .fir_load_o   (fir_load_o),
    .fir_cycle_o  (fir_cycle_o),
    .fir_result_i (fir_result_i),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_wr       (cfg_wr),
    .cfg_ready    (cfg_ready),
    .coeff_addr   (coeff_addr),
    .coeff_wdata  (coeff_wdata),
    .coeff_wr     (coeff_wr),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present a sample and complete the handshake; in random mode ready/ce
  // are shuffled while the scheduler is busy.
  task automatic send_hs(input logic [DW-1:0] data, input bit rnd);
    int w;
    w = 0;
    s_tdata  = data;
    s_tvalid = 1'b1;
    #1;
    while (!s_tready && w < 100) begin
      @(posedge sys_clk);
      #1;
      w++;
      if (rnd) begin
        m_tready = 1'($urandom_range(0, 1));
        ce       = ($urandom_range(0, 3) != 0);
      end
      #1;
    end
    if (!s_tready) begin
      chk("send_timeout", 64'(s_tready), 64'(1));
      s_tvalid = 1'b0;
    end else begin
      @(posedge sys_clk);
      exp_q.push_back(data ^ KEY);
      #1;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic wait_valid(inout int n);
    int w;
    w = 0;
    while (w < 100) begin
      @(posedge sys_clk);
      #1;
      n++;
      w++;
      if (m_tvalid) break;
    end
    if (!m_tvalid) chk("valid_timeout", 64'(m_tvalid), 64'(1));
  endtask

  // Scoreboard: every completed output handshake must match the oldest
  // outstanding prediction.
  always @(negedge sys_clk) begin
    if (reset_n && ce && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("m_tvalid_spurious", 64'(m_tvalid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("m_tdata_order", 64'(m_tdata), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ce = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    cfg_addr = '0; cfg_wdata = '0; cfg_wr = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_busy",     64'(busy_o),   64'(0));
    chk("rst_load",     64'(fir_load_o), 64'(0));
    chk("rst_cycle",    64'(fir_cycle_o), 64'(0));
    chk("rst_coeff_wr", 64'(coeff_wr), 64'(0));
    reset_n = 1'b1;
    tick();
    chk("ce_low_s_tready", 64'(s_tready), 64'(0));
    ce = 1'b1;
    #1;
    chk("post_rst_s_tready",  64'(s_tready),  64'(1));
    chk("post_rst_cfg_ready", 64'(cfg_ready), 64'(1));

    // ---- single sample 0x1234 ----
    s_tdata = 16'h1234; s_tvalid = 1'b1;
    #1;
    chk("s1_s_tready", 64'(s_tready), 64'(1));
    @(posedge sys_clk);
    exp_q.push_back(16'h1234 ^ KEY);
    #1;
    s_tvalid = 1'b0;
    chk("s1_load",   64'(fir_load_o),   64'(1));
    chk("s1_sample", 64'(fir_sample_o), 64'(16'h1234));
    chk("s1_busy",   64'(busy_o),       64'(1));
    chk("s1_cycle0", 64'(fir_cycle_o),  64'(0));
    for (int i = 1; i < N; i++) begin
      tick();
      chk("s1_cycle", 64'(fir_cycle_o), 64'(i));
      if (i == 1) chk("s1_load_pulse", 64'(fir_load_o), 64'(0));
    end
    tick();
    chk("s1_cycle_wait", 64'(fir_cycle_o), 64'(0));
    chk("s1_busy_wait",  64'(busy_o),      64'(1));
    lat = N;
    wait_valid(lat);
    chk("s1_latency", 64'(lat),      64'(N + LAT));
    chk("s1_m_tdata", 64'(m_tdata),  64'(16'h1234 ^ KEY));
    chk("s1_idle",    64'(busy_o),   64'(0));
    chk("s1_rdy_next",64'(s_tready), 64'(1));

    // ---- collision: coefficient write beats the sample ----
    tick();
    d = DW'($urandom);
    cfg_addr = 8'h03; cfg_wdata = 32'hDEADBEEF; cfg_wr = 1'b1;
    s_tdata = d; s_tvalid = 1'b1;
    #1;
    chk("col_s_tready",  64'(s_tready),  64'(0));
    chk("col_cfg_ready", 64'(cfg_ready), 64'(1));
    tick();
    chk("col_coeff_wr",    64'(coeff_wr),    64'(1));
    chk("col_coeff_addr",  64'(coeff_addr),  64'(8'h03));
    chk("col_coeff_wdata", 64'(coeff_wdata), 64'(32'hDEADBEEF));
    chk("col_no_load",     64'(fir_load_o),  64'(0));
    cfg_wr = 1'b0;
    #1;
    chk("col_s_tready_next", 64'(s_tready), 64'(1));
    @(posedge sys_clk);
    exp_q.push_back(d ^ KEY);
    #1;
    s_tvalid = 1'b0;
    chk("col_load",     64'(fir_load_o),   64'(1));
    chk("col_wr_pulse", 64'(coeff_wr),     64'(0));
    chk("col_sample",   64'(fir_sample_o), 64'(d));
    lat = 0;
    wait_valid(lat);
    chk("col_latency", 64'(lat), 64'(N + LAT));

    // ---- coefficient write held during a sample ----
    tick();
    send_hs(DW'($urandom), 1'b0);
    ra = 8'($urandom); rw = $urandom;
    cfg_addr = ra; cfg_wdata = rw; cfg_wr = 1'b1;
    #1;
    chk("blk_cfg_ready", 64'(cfg_ready), 64'(0));
    wr_cnt = 0; wr_at = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 5) chk("blk_cfg_ready_run", 64'(cfg_ready), 64'(0));
      if (coeff_wr) begin
        wr_cnt++;
        wr_at = k;
        chk("blk_addr",  64'(coeff_addr),  64'(ra));
        chk("blk_wdata", 64'(coeff_wdata), 64'(rw));
        cfg_wr = 1'b0;
      end
    end
    chk("blk_wr_count", 64'(wr_cnt), 64'(1));
    chk("blk_wr_time",  64'(wr_at),  64'(N + LAT + 1));

    // ---- backpressure with two samples ----
    m_tready = 1'b0;
    dA = DW'($urandom);
    dB = DW'($urandom);
    send_hs(dA, 1'b0);
    lat = 0;
    wait_valid(lat);
    chk("bp_latency_a", 64'(lat), 64'(N + LAT));
    send_hs(dB, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k % 4 == 0) begin
        chk("bp_hold_valid", 64'(m_tvalid), 64'(1));
        chk("bp_hold_data",  64'(m_tdata),  64'(dA ^ KEY));
      end
    end
    chk("bp_stall_busy", 64'(busy_o), 64'(1));
    m_tready = 1'b1;
    tick();
    chk("bp_b_valid", 64'(m_tvalid), 64'(1));
    chk("bp_b_data",  64'(m_tdata),  64'(dB ^ KEY));
    chk("bp_b_idle",  64'(busy_o),   64'(0));
    tick();
    chk("bp_drained", 64'(m_tvalid), 64'(0));
    chk("bp_queue",   64'(exp_q.size()), 64'(0));

    // ---- clock-enable gap at cycle 4 ----
    send_hs(DW'($urandom), 1'b0);
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      lat++;
      chk("ce_cycle", 64'(fir_cycle_o), 64'(i));
    end
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat++;
      chk("ce_hold", 64'(fir_cycle_o), 64'(4));
    end
    chk("ce_low_cfg_ready", 64'(cfg_ready), 64'(0));
    ce = 1'b1;
    tick();
    lat++;
    chk("ce_resume", 64'(fir_cycle_o), 64'(5));
    wait_valid(lat);
    chk("ce_latency", 64'(lat), 64'(N + LAT + 3));

    // ---- reset while waiting for the result ----
    tick();
    send_hs(DW'($urandom), 1'b0);
    repeat (9) tick();
    chk("rw_busy",    64'(busy_o),   64'(1));
    chk("rw_novalid", 64'(m_tvalid), 64'(0));
    reset_n = 1'b0;
    ce = 1'b0;
    #1;
    exp_q.delete();
    chk("rw_m_tdata",      64'(m_tdata),      64'(0));
    chk("rw_m_tvalid",     64'(m_tvalid),     64'(0));
    chk("rw_sample",       64'(fir_sample_o), 64'(0));
    chk("rw_busy_rst",     64'(busy_o),       64'(0));
    chk("rw_coeff_addr",   64'(coeff_addr),   64'(0));
    chk("rw_coeff_wdata",  64'(coeff_wdata),  64'(0));
    chk("rw_cycle",        64'(fir_cycle_o),  64'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    ce = 1'b1;
    #1;
    chk("rw_s_tready", 64'(s_tready), 64'(1));
    spur = 1'b0;
    repeat (15) begin
      tick();
      if (m_tvalid) spur = 1'b1;
    end
    chk("rw_no_output", 64'(spur), 64'(0));

    // ---- randomized traffic with random ready and enable ----
    for (int k = 0; k < 8; k++) begin
      send_hs(DW'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) begin
        tick();
        m_tready = 1'($urandom_range(0, 1));
        ce       = ($urandom_range(0, 3) != 0);
      end
    end
    ce = 1'b1;
    m_tready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    chk("rnd_all_delivered", 64'(exp_q.size()), 64'(0));
    tick();
    chk("rnd_final_valid", 64'(m_tvalid), 64'(0));
    chk("rnd_final_idle",  64'(busy_o),   64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
